uart_f2c_tx: RTL and testbench

- Fabric-side responder that gives the UART tile a memory-mapped transmit path, so any core on the ring can send bytes out of the UART.
- Services F2C requests (RD/WR) delivered by the tile's rc and returns exactly one F2C response per request.
- Writes to TXDATA push bytes into a TX FIFO; a baud-rate serializer drains the FIFO onto uart_tx, 8N1, LSB first.

---
 rtl/lotr_pkg.sv | 30 +++
 rtl/uart_tx_serializer.sv | 88 ++++++++
 rtl/uart_f2c_tx.sv | 141 ++++++++++++++
 tb/tb_uart_f2c_tx.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lotr_pkg.sv
// Shared ring types plus the UART transmit-tile register map.
// Holds F2C opcodes, UART register offsets and serializer states.
package lotr_pkg;

  typedef enum logic [2:0] {
    NOP    = 3'd0,
    RD     = 3'd1,
    WR     = 3'd2,
    RD_RSP = 3'd3,
    WR_RSP = 3'd4
  } t_opcode;

  localparam logic [1:0] UART_TXDATA_OFF = 2'd0;
  localparam logic [1:0] UART_STATUS_OFF = 2'd1;
  localparam logic [1:0] UART_CTRL_OFF   = 2'd2;
  localparam logic [1:0] UART_BAUD_OFF   = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } t_uart_tx_state;

  // A programmed divisor of 0 behaves as 1.
  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return (d == 16'd0) ? 16'd1 : d;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 LSB-first serializer: pops a byte when idle and valid, then
// clocks start/data/stop bits each div cycles. Ports: clk, rst_n, data, valid, div, pop, tx, busy.
module uart_tx_serializer
  import lotr_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  data,
  input  logic        valid,
  input  logic [15:0] div,
  output logic        pop,
  output logic        tx,
  output logic        busy
);

  t_uart_tx_state state;
  logic [15:0]    div_l;
  logic [15:0]    cnt;
  logic [2:0]     bit_idx;
  logic [7:0]     shreg;
  logic           last;

  assign pop  = (state == IDLE) && valid;
  assign busy = (state != IDLE);
  assign last = (cnt == div_l - 16'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      tx      <= 1'b1;
      div_l   <= 16'd1;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (valid) begin
            state   <= START;
            tx      <= 1'b0;
            div_l   <= eff_div(div);
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= data;
          end
        end
        START: begin
          if (last) begin
            state <= DATA;
            cnt   <= '0;
            tx    <= shreg[0];
            shreg <= shreg >> 1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DATA: begin
          if (last) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        STOP: begin
          if (last) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_f2c_tx.sv
// F2C register responder for the UART tile: TXDATA/STATUS/CTRL/BAUD_DIV,
// TX FIFO, one response per RD/WR, serial uart_tx and level tx_irq.
module uart_f2c_tx
  import lotr_pkg::*;
#(
  parameter int FIFO_DEPTH       = 16,
  parameter int BAUD_DIV_DEFAULT = 434
) (
  input  logic        QClk,
  input  logic        RstQnnnH,
  input  logic        F2C_ReqValidQ502H,
  input  t_opcode     F2C_ReqOpcodeQ502H,
  input  logic [31:0] F2C_ReqAddressQ502H,
  input  logic [31:0] F2C_ReqDataQ502H,
  output logic        F2C_RspValidQ500H,
  output t_opcode     F2C_RspOpcodeQ500H,
  output logic [31:0] F2C_RspAddressQ500H,
  output logic [31:0] F2C_RspDataQ500H,
  output logic        uart_tx,
  output logic        tx_irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  logic        tx_en;
  logic        irq_en;
  logic [15:0] baud;
  logic        ovf;

  logic        req_rd;
  logic        req_wr;
  logic [1:0]  off;
  logic        push;
  logic        push_ok;
  logic        ovf_set;
  logic        clr_ovf;
  logic        wr_ctrl;
  logic        wr_baud;
  logic        pop;
  logic        busy;
  logic [31:0] status;
  logic [31:0] rd_data;

  assign off    = F2C_ReqAddressQ502H[3:2];
  assign req_rd = F2C_ReqValidQ502H && (F2C_ReqOpcodeQ502H == RD);
  assign req_wr = F2C_ReqValidQ502H && (F2C_ReqOpcodeQ502H == WR);

  assign push    = req_wr && (off == UART_TXDATA_OFF);
  assign wr_ctrl = req_wr && (off == UART_CTRL_OFF);
  assign wr_baud = req_wr && (off == UART_BAUD_OFF);
  assign clr_ovf = wr_ctrl && F2C_ReqDataQ502H[1];

  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);

  // A full FIFO still takes a byte when the serializer pops in the same cycle.
  assign push_ok = push && (!full || pop);
  assign ovf_set = push && !push_ok;

  assign tx_irq = irq_en && empty && !busy;

  always_comb begin
    status        = '0;
    status[0]     = busy;
    status[1]     = empty;
    status[2]     = full;
    status[3]     = ovf;
    status[15:8]  = 8'(count);
  end

  always_comb begin
    rd_data = '0;
    unique case (1'b1)
      (off == UART_STATUS_OFF): rd_data = status;
      (off == UART_CTRL_OFF):   rd_data = {29'd0, irq_en, 1'b0, tx_en};
      (off == UART_BAUD_OFF):   rd_data = {16'd0, baud};
      default:                  rd_data = '0;
    endcase
  end

  always_ff @(posedge QClk) begin
    if (push_ok) mem[wptr] <= F2C_ReqDataQ502H[7:0];
  end

  always_ff @(posedge QClk or negedge RstQnnnH) begin
    if (!RstQnnnH) begin
      tx_en  <= 1'b1;
      irq_en <= 1'b0;
      baud   <= 16'(BAUD_DIV_DEFAULT);
      ovf    <= 1'b0;
      count  <= '0;
      wptr   <= '0;
      rptr   <= '0;
    end else begin
      if (wr_ctrl) begin
        tx_en  <= F2C_ReqDataQ502H[0];
        irq_en <= F2C_ReqDataQ502H[2];
      end
      if (wr_baud) baud <= F2C_ReqDataQ502H[15:0];
      // A fresh overflow wins over a simultaneous clear.
      ovf <= ovf_set || (ovf && !clr_ovf);
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      count <= count + CW'(push_ok) - CW'(pop);
    end
  end

  always_ff @(posedge QClk or negedge RstQnnnH) begin
    if (!RstQnnnH) begin
      F2C_RspValidQ500H   <= 1'b0;
      F2C_RspOpcodeQ500H  <= RD_RSP;
      F2C_RspAddressQ500H <= '0;
      F2C_RspDataQ500H    <= '0;
    end else begin
      F2C_RspValidQ500H   <= req_rd || req_wr;
      F2C_RspOpcodeQ500H  <= req_wr ? WR_RSP : RD_RSP;
      F2C_RspAddressQ500H <= (req_rd || req_wr) ? F2C_ReqAddressQ502H : '0;
      F2C_RspDataQ500H    <= req_rd ? rd_data : '0;
    end
  end

  uart_tx_serializer u_ser (
    .clk   (QClk),
    .rst_n (RstQnnnH),
    .data  (mem[rptr]),
    .valid (tx_en && !empty),
    .div   (baud),
    .pop   (pop),
    .tx    (uart_tx),
    .busy  (busy)
  );

endmodule

// File: tb/tb_uart_f2c_tx.sv
// Directed bench for uart_f2c_tx: register access, framing, FIFO overflow,
// back-to-back responses, interrupt timing and asynchronous reset.
module tb_uart_f2c_tx;
  import lotr_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  t_opcode     req_op;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        rsp_valid;
  t_opcode     rsp_op;
  logic [31:0] rsp_addr;
  logic [31:0] rsp_data;
  logic        uart_tx;
  logic        tx_irq;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_f2c_tx dut (
    .QClk                (clk),
    .RstQnnnH            (rst_n),
    .F2C_ReqValidQ502H   (req_valid),
    .F2C_ReqOpcodeQ502H  (req_op),
    .F2C_ReqAddressQ502H (req_addr),
    .F2C_ReqDataQ502H    (req_data),
    .F2C_RspValidQ500H   (rsp_valid),
    .F2C_RspOpcodeQ500H  (rsp_op),
    .F2C_RspAddressQ500H (rsp_addr),
    .F2C_RspDataQ500H    (rsp_data),
    .uart_tx             (uart_tx),
    .tx_irq              (tx_irq)
  );

  // Drive one request for a single cycle; returns on the negedge where
  // its response is visible.
  task automatic issue(input t_opcode op, input logic [31:0] a,
                       input logic [31:0] d);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = a;
    req_data  = d;
    @(negedge clk);
    req_valid = 1'b0;
    req_op    = NOP;
    req_addr  = '0;
    req_data  = '0;
  endtask

  // Receive one frame; skew = cycles of start bit already elapsed.
  task automatic rx_byte(input int div, input int skew,
                         output logic [7:0] b, output bit ok);
    int n;
    int pos;
    int t;
    ok = 1'b1;
    b  = '0;
    n  = 0;
    while (uart_tx !== 1'b0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (uart_tx !== 1'b0) begin
      ok = 1'b0;
    end else begin
      pos = skew;
      t = div / 2;
      while (pos < t) begin @(negedge clk); pos++; end
      if (uart_tx !== 1'b0) ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
        t = div * (i + 1) + div / 2;
        while (pos < t) begin @(negedge clk); pos++; end
        b[i] = uart_tx;
      end
      t = div * 9 + div / 2;
      while (pos < t) begin @(negedge clk); pos++; end
      if (uart_tx !== 1'b1) ok = 1'b0;
      t = div * 10 - 1;
      while (pos < t) begin @(negedge clk); pos++; end
    end
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = NOP;
    req_addr  = '0;
    req_data  = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_op, rsp_addr, rsp_data, uart_tx, tx_irq} !==
        {1'b0, RD_RSP, 32'd0, 32'd0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL reset_outputs: got v=%b op=%0d a=%h d=%h tx=%b irq=%b",
               rsp_valid, rsp_op, rsp_addr, rsp_data, uart_tx, tx_irq);
    end
    rst_n = 1'b1;
    @(negedge clk);
    issue(RD, 32'h4, 32'h0);
    checks++;
    if ({rsp_valid, rsp_op, rsp_addr, rsp_data} !==
        {1'b1, RD_RSP, 32'h4, 32'h2}) begin
      failures++;
      $display("FAIL reset_status: got v=%b op=%0d a=%h d=%h want d=00000002",
               rsp_valid, rsp_op, rsp_addr, rsp_data);
    end
    checks++;
    if ({uart_tx, tx_irq} !== 2'b10) begin
      failures++;
      $display("FAIL reset_line: got tx=%b irq=%b want 1 0", uart_tx, tx_irq);
    end
    issue(RD, 32'hC, 32'h0);
    checks++;
    if (rsp_data !== 32'd434) begin
      failures++;
      $display("FAIL reset_baud: got %0d want 434", rsp_data);
    end
    issue(RD, 32'h8, 32'h0);
    checks++;
    if (rsp_data !== 32'h1) begin
      failures++;
      $display("FAIL reset_ctrl: got %h want 00000001", rsp_data);
    end
  endtask

  task automatic test_frame_55;
    logic [39:0] obs;
    logic [39:0] exp;
    logic [9:0]  pat;
    logic [31:0] st;
    pat = {1'b1, 8'h55, 1'b0};
    st  = '0;
    issue(WR, 32'hC, 32'd4);
    checks++;
    if ({rsp_valid, rsp_op, rsp_addr, rsp_data} !==
        {1'b1, WR_RSP, 32'hC, 32'h0}) begin
      failures++;
      $display("FAIL baud_wr_rsp: got v=%b op=%0d a=%h d=%h",
               rsp_valid, rsp_op, rsp_addr, rsp_data);
    end
    issue(WR, 32'h0, 32'h55);
    checks++;
    if (uart_tx !== 1'b1) begin
      failures++;
      $display("FAIL pre_start_idle: got tx=%b want 1", uart_tx);
    end
    for (int k = 0; k < 40; k++) begin
      if (k == 10) begin
        issue(RD, 32'h4, 32'h0);
        st = rsp_data;
      end else begin
        @(negedge clk);
      end
      obs[k] = uart_tx;
      exp[k] = pat[k / 4];
    end
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL frame_55: got %h want %h", obs, exp);
    end
    checks++;
    if (st !== 32'h3) begin
      failures++;
      $display("FAIL busy_mid_frame: got %h want 00000003", st);
    end
  endtask

  task automatic test_irq;
    logic [9:0] obs;
    logic       irq_seen;
    issue(WR, 32'h8, 32'h5);
    checks++;
    if (tx_irq !== 1'b1) begin
      failures++;
      $display("FAIL irq_idle: got %b want 1", tx_irq);
    end
    issue(WR, 32'h0, 32'hA3);
    checks++;
    if (tx_irq !== 1'b0) begin
      failures++;
      $display("FAIL irq_at_push: got %b want 0", tx_irq);
    end
    irq_seen = 1'b0;
    obs = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (tx_irq !== 1'b0) irq_seen = 1'b1;
      if (k % 4 == 2) obs[k / 4] = uart_tx;
    end
    checks++;
    if (irq_seen !== 1'b0) begin
      failures++;
      $display("FAIL irq_during_frame: got 1 want 0");
    end
    checks++;
    if (obs !== {1'b1, 8'hA3, 1'b0}) begin
      failures++;
      $display("FAIL frame_a3: got %h want %h", obs, {1'b1, 8'hA3, 1'b0});
    end
    @(negedge clk);
    checks++;
    if (tx_irq !== 1'b1) begin
      failures++;
      $display("FAIL irq_after_stop: got %b want 1", tx_irq);
    end
  endtask

  task automatic test_overflow;
    int         nrsp;
    logic [7:0] b;
    bit         ok;
    issue(WR, 32'h8, 32'h0);
    nrsp = 0;
    for (int i = 0; i < 17; i++) begin
      issue(WR, 32'h0, 32'h30 + i);
      if (rsp_valid === 1'b1 && rsp_op === WR_RSP) nrsp++;
    end
    checks++;
    if (nrsp != 17) begin
      failures++;
      $display("FAIL ovf_rsp_count: got %0d want 17", nrsp);
    end
    issue(RD, 32'h4, 32'h0);
    checks++;
    if (rsp_data !== 32'h100C) begin
      failures++;
      $display("FAIL ovf_status: got %h want 0000100c", rsp_data);
    end
    issue(WR, 32'h8, 32'h3);
    issue(RD, 32'h4, 32'h0);
    checks++;
    if (rsp_data !== 32'h1004) begin
      failures++;
      $display("FAIL ovf_cleared: got %h want 00001004", rsp_data);
    end
    for (int i = 0; i < 16; i++) begin
      rx_byte(4, 0, b, ok);
      checks++;
      if ({ok, b} !== {1'b1, 8'(8'h30 + i)}) begin
        failures++;
        $display("FAIL drain_%0d: got ok=%b b=%h want %h", i, ok, b,
                 8'(8'h30 + i));
      end
    end
    @(negedge clk);
    issue(RD, 32'h4, 32'h0);
    checks++;
    if (rsp_data !== 32'h2) begin
      failures++;
      $display("FAIL drained_status: got %h want 00000002", rsp_data);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] b;
    bit         ok;
    issue(WR, 32'h4000_0000, 32'h5A);
    checks++;
    if ({rsp_valid, rsp_op, rsp_addr, rsp_data} !==
        {1'b1, WR_RSP, 32'h4000_0000, 32'h0}) begin
      failures++;
      $display("FAIL b2b_wr: got v=%b op=%0d a=%h d=%h",
               rsp_valid, rsp_op, rsp_addr, rsp_data);
    end
    issue(RD, 32'h4000_0004, 32'h0);
    checks++;
    if ({rsp_valid, rsp_op, rsp_addr, rsp_data} !==
        {1'b1, RD_RSP, 32'h4000_0004, 32'h100}) begin
      failures++;
      $display("FAIL b2b_status: got v=%b op=%0d a=%h d=%h want d=00000100",
               rsp_valid, rsp_op, rsp_addr, rsp_data);
    end
    issue(RD, 32'h4000_0008, 32'h0);
    checks++;
    if ({rsp_valid, rsp_op, rsp_addr, rsp_data} !==
        {1'b1, RD_RSP, 32'h4000_0008, 32'h1}) begin
      failures++;
      $display("FAIL b2b_ctrl: got v=%b op=%0d a=%h d=%h want d=00000001",
               rsp_valid, rsp_op, rsp_addr, rsp_data);
    end
    rx_byte(4, 1, b, ok);
    checks++;
    if ({ok, b} !== {1'b1, 8'h5A}) begin
      failures++;
      $display("FAIL b2b_frame: got ok=%b b=%h want 5a", ok, b);
    end
  endtask

  task automatic test_nop;
    issue(NOP, 32'h0, 32'h77);
    checks++;
    if ({rsp_valid, rsp_addr} !== 33'd0) begin
      failures++;
      $display("FAIL nop_no_rsp: got v=%b a=%h", rsp_valid, rsp_addr);
    end
    issue(RD, 32'h4, 32'h0);
    checks++;
    if (rsp_data !== 32'h2) begin
      failures++;
      $display("FAIL nop_no_push: got %h want 00000002", rsp_data);
    end
  endtask

  task automatic test_baud_zero;
    logic [7:0] b;
    bit         ok;
    issue(WR, 32'hC, 32'h0);
    issue(RD, 32'hC, 32'h0);
    checks++;
    if (rsp_data !== 32'h0) begin
      failures++;
      $display("FAIL baud0_read: got %h want 00000000", rsp_data);
    end
    issue(WR, 32'h0, 32'h96);
    rx_byte(1, 0, b, ok);
    checks++;
    if ({ok, b} !== {1'b1, 8'h96}) begin
      failures++;
      $display("FAIL baud0_frame: got ok=%b b=%h want 96", ok, b);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    issue(WR, 32'hC, 32'd4);
    issue(WR, 32'h0, 32'h00);
    issue(WR, 32'h0, 32'hFF);
    repeat (12) @(negedge clk);
    checks++;
    if (uart_tx !== 1'b0) begin
      failures++;
      $display("FAIL mid_data_low: got %b want 0", uart_tx);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({uart_tx, rsp_valid} !== 2'b10) begin
      failures++;
      $display("FAIL async_reset: got tx=%b v=%b want 1 0", uart_tx, rsp_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(RD, 32'h4, 32'h0);
    checks++;
    if (rsp_data !== 32'h2) begin
      failures++;
      $display("FAIL post_reset_status: got %h want 00000002", rsp_data);
    end
    issue(RD, 32'hC, 32'h0);
    checks++;
    if ({rsp_data, uart_tx} !== {32'd434, 1'b1}) begin
      failures++;
      $display("FAIL post_reset_baud: got %0d tx=%b want 434 1",
               rsp_data, uart_tx);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_frame_55();
    test_irq();
    test_overflow();
    test_back_to_back();
    test_nop();
    test_baud_zero();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
